ascon_aead_stream: RTL and testbench

Parametrised ASCON-AEAD128 core with run-time encrypt/decrypt mode, multi-block associated data and message, and a valid/ready input handshake. It runs initialisation, AD absorption, message processing and finalisation on an internal 320-bit state register. The core applies UNROLL rounds per clock through chained instances of the team's combinational ASCON round, and compares tags in decrypt mode. It sits under the system top as the single crypto engine.

---
 rtl/ascon_aead_stream.sv | 259 +++++++++++++++++++++++++
 tb/tb_ascon_aead_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead_stream.sv
// ASCON-AEAD128 streaming core: init, multi-block AD, encrypt/decrypt and tag
// generation on a 320-bit sponge, UNROLL combinational rounds per clock.

module ascon_round (
    input  logic [319:0] state_i,
    input  logic [3:0]   rnd_i,
    output logic [319:0] state_o
);
    logic [7:0]  rc;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a2, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    always_comb begin
        rc = {4'hF - rnd_i, rnd_i};
        x0 = state_i[319:256];
        x1 = state_i[255:192];
        x2 = state_i[191:128] ^ {56'd0, rc};
        x3 = state_i[127:64];
        x4 = state_i[63:0];
        // Bitsliced 5-bit S-box
        a0 = x0 ^ x4;
        a4 = x4 ^ x3;
        a2 = x2 ^ x1;
        b0 = a0 ^ (~x1 & a2);
        b1 = x1 ^ (~a2 & x3);
        b2 = a2 ^ (~x3 & a4);
        b3 = x3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & x1);
        s0 = b0 ^ b4;
        s1 = b1 ^ b0;
        s2 = ~b2;
        s3 = b3 ^ b2;
        s4 = b4;
        state_o = {s0 ^ ror(s0, 19) ^ ror(s0, 28),
                   s1 ^ ror(s1, 61) ^ ror(s1, 39),
                   s2 ^ ror(s2, 1)  ^ ror(s2, 6),
                   s3 ^ ror(s3, 10) ^ ror(s3, 17),
                   s4 ^ ror(s4, 7)  ^ ror(s4, 41)};
    end
endmodule

module ascon_aead_stream #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     nonce_i,
    input  logic [CNT_W-1:0] ad_blocks_i,
    input  logic [CNT_W-1:0] msg_blocks_i,
    input  logic [127:0]     data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [127:0]     tag_i,
    output logic [127:0]     cipher_o,
    output logic             cipher_valid_o,
    output logic [127:0]     tag_o,
    output logic             tag_ok_o,
    output logic             busy_o,
    output logic             end_o,
    output logic             cmd_err_o
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("ascon_aead_stream: UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {IDLE, INIT, AD_WAIT, AD_PERM, MSG_WAIT, MSG_PERM, FINAL} fsm_e;

    localparam logic [63:0] IV       = 64'h00001000808c0001;
    localparam logic [3:0]  STEP     = 4'(UNROLL);
    localparam logic [3:0]  LAST_RND = 4'(12 - UNROLL);

    fsm_e             fsm_q, fsm_d;
    logic [319:0]     s_q, s_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d, msg_cnt_q, msg_cnt_d;
    logic             mode_q, mode_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     cipher_q, cipher_d, tag_q, tag_d;
    logic             cipher_valid_q, cipher_valid_d, tag_ok_q, tag_ok_d;
    logic             end_q, end_d, cmd_err_q, cmd_err_d;
    logic [127:0]     keyw, msg_out;
    logic             rnd_last, tag_match;
    logic [319:0]     chain [UNROLL+1];

    assign chain[0] = s_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_i (chain[g]),
            .rnd_i   (rnd_q + 4'(g)),
            .state_o (chain[g+1])
        );
    end

    assign keyw      = {key_q[63:0], key_q[127:64]};
    assign rnd_last  = (rnd_q == LAST_RND);
    assign tag_match = mode_q & (tag_q == tag_i);

    always_comb begin
        fsm_d          = fsm_q;
        s_d            = s_q;
        rnd_d          = rnd_q;
        ad_cnt_d       = ad_cnt_q;
        msg_cnt_d      = msg_cnt_q;
        mode_d         = mode_q;
        key_d          = key_q;
        cipher_d       = cipher_q;
        cipher_valid_d = 1'b0;
        tag_d          = tag_q;
        tag_ok_d       = tag_ok_q;
        end_d          = 1'b0;
        cmd_err_d      = 1'b0;
        data_ready_o   = 1'b0;
        msg_out        = '0;
        case (fsm_q)
            IDLE: begin
                // tag_i is compared during the end_o cycle and the verdict held afterwards
                if (end_q) tag_ok_d = tag_match;
                if (start_i) begin
                    if (msg_blocks_i == '0) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        mode_d    = mode_i;
                        key_d     = key_i;
                        ad_cnt_d  = ad_blocks_i;
                        msg_cnt_d = msg_blocks_i;
                        s_d       = {IV, key_i[63:0], key_i[127:64], nonce_i[63:0], nonce_i[127:64]};
                        rnd_d     = '0;
                        tag_d     = '0;
                        tag_ok_d  = 1'b0;
                        fsm_d     = INIT;
                    end
                end
            end
            INIT: begin
                s_d   = chain[UNROLL];
                rnd_d = rnd_q + STEP;
                if (rnd_last) begin
                    rnd_d       = '0;
                    s_d[127:0]  = chain[UNROLL][127:0] ^ keyw;
                    if (ad_cnt_q == '0) begin
                        s_d[63] = ~s_d[63];
                        fsm_d   = MSG_WAIT;
                    end else begin
                        fsm_d   = AD_WAIT;
                    end
                end
            end
            AD_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    s_d[319:192] = s_q[319:192] ^ data_i;
                    ad_cnt_d     = ad_cnt_q - CNT_W'(1);
                    rnd_d        = 4'd4;
                    fsm_d        = AD_PERM;
                end
            end
            AD_PERM: begin
                s_d   = chain[UNROLL];
                rnd_d = rnd_q + STEP;
                if (rnd_last) begin
                    rnd_d = '0;
                    if (ad_cnt_q != '0) begin
                        fsm_d = AD_WAIT;
                    end else begin
                        s_d[63] = ~chain[UNROLL][63];
                        fsm_d   = MSG_WAIT;
                    end
                end
            end
            MSG_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    msg_out        = s_q[319:192] ^ data_i;
                    cipher_d       = msg_out;
                    cipher_valid_d = 1'b1;
                    s_d[319:192]   = mode_q ? data_i : msg_out;
                    msg_cnt_d      = msg_cnt_q - CNT_W'(1);
                    if (msg_cnt_q == CNT_W'(1)) begin
                        s_d[191:64] = s_q[191:64] ^ keyw;
                        rnd_d       = '0;
                        fsm_d       = FINAL;
                    end else begin
                        rnd_d       = 4'd4;
                        fsm_d       = MSG_PERM;
                    end
                end
            end
            MSG_PERM: begin
                s_d   = chain[UNROLL];
                rnd_d = rnd_q + STEP;
                if (rnd_last) begin
                    rnd_d = '0;
                    fsm_d = MSG_WAIT;
                end
            end
            FINAL: begin
                s_d   = chain[UNROLL];
                rnd_d = rnd_q + STEP;
                if (rnd_last) begin
                    rnd_d = '0;
                    tag_d = chain[UNROLL][127:0] ^ keyw;
                    end_d = 1'b1;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q          <= IDLE;
            s_q            <= '0;
            rnd_q          <= '0;
            ad_cnt_q       <= '0;
            msg_cnt_q      <= '0;
            mode_q         <= 1'b0;
            key_q          <= '0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            tag_q          <= '0;
            tag_ok_q       <= 1'b0;
            end_q          <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            s_q            <= s_d;
            rnd_q          <= rnd_d;
            ad_cnt_q       <= ad_cnt_d;
            msg_cnt_q      <= msg_cnt_d;
            mode_q         <= mode_d;
            key_q          <= key_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
            tag_q          <= tag_d;
            tag_ok_q       <= tag_ok_d;
            end_q          <= end_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign cipher_o       = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign tag_o          = tag_q;
    assign tag_ok_o       = end_q ? tag_match : tag_ok_q;
    assign busy_o         = (fsm_q != IDLE);
    assign end_o          = end_q;
    assign cmd_err_o      = cmd_err_q;
endmodule

// File: tb/tb_ascon_aead_stream.sv
// Directed bench for ascon_aead_stream with an independent table-driven ASCON model.

module tb_ascon_aead_stream;
    localparam int UNROLL = 1;

    logic         clk = 1'b0;
    logic         reset_i, start_i, mode_i, data_valid_i;
    logic [127:0] key_i, nonce_i, data_i, tag_i;
    logic [7:0]   ad_blocks_i, msg_blocks_i;
    logic         data_ready_o, cipher_valid_o, tag_ok_o, busy_o, end_o, cmd_err_o;
    logic [127:0] cipher_o, tag_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] ad_v [8];
    logic [127:0] msg_v [8];
    logic [127:0] pt_save [8];
    logic [127:0] exp_out [8];
    logic [127:0] exp_tag, t_enc, k1, n1;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    always #5 clk = ~clk;

    ascon_aead_stream #(.UNROLL(UNROLL), .CNT_W(8)) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .key_i          (key_i),
        .nonce_i        (nonce_i),
        .ad_blocks_i    (ad_blocks_i),
        .msg_blocks_i   (msg_blocks_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .tag_i          (tag_i),
        .cipher_o       (cipher_o),
        .cipher_valid_o (cipher_valid_o),
        .tag_o          (tag_o),
        .tag_ok_o       (tag_ok_o),
        .busy_o         (busy_o),
        .end_o          (end_o),
        .cmd_err_o      (cmd_err_o)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [4:0]  c;
        logic [7:0]  rc;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        rc = 8'(((15 - r) << 4) | r);
        x[2][7:0] = x[2][7:0] ^ rc;
        for (int j = 0; j < 64; j++) begin
            c = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
            x[0][j] = c[4]; x[1][j] = c[3]; x[2][j] = c[2]; x[3][j] = c[1]; x[4][j] = c[0];
        end
        x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int first);
        for (int r = first; r < 12; r++) s = m_round(s, r);
        return s;
    endfunction

    task automatic model(input logic dec, input logic [127:0] k, input logic [127:0] n,
                         input int nad, input int nmsg);
        logic [319:0] s;
        logic [127:0] kw, o;
        kw = {k[63:0], k[127:64]};
        s  = {64'h00001000808c0001, kw, n[63:0], n[127:64]};
        s  = m_perm(s, 0);
        s[127:0] = s[127:0] ^ kw;
        for (int i = 0; i < nad; i++) begin
            s[319:192] = s[319:192] ^ ad_v[i];
            s = m_perm(s, 4);
        end
        s[63] = ~s[63];
        for (int i = 0; i < nmsg; i++) begin
            o = s[319:192] ^ msg_v[i];
            exp_out[i] = o;
            s[319:192] = dec ? msg_v[i] : o;
            if (i < nmsg - 1) s = m_perm(s, 4);
        end
        s[191:64] = s[191:64] ^ kw;
        s = m_perm(s, 0);
        exp_tag = s[127:0] ^ kw;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input string name, input logic dec, input logic [127:0] k,
                          input logic [127:0] n, input int nad, input int nmsg,
                          input logic [127:0] tin, input int gmax, input bit poke,
                          input logic exp_ok);
        int  cyc, beat, nout, gap, total, exp_cyc;
        logic rdy_prev;
        bit  done, saw_err;
        model(dec, k, n, nad, nmsg);
        total   = nad + nmsg;
        exp_cyc = 1 + 12/UNROLL + nad*(1 + 8/UNROLL) + nmsg + (nmsg - 1)*(8/UNROLL) + 12/UNROLL + 1;
        @(negedge clk);
        start_i = 1'b1; mode_i = dec; key_i = k; nonce_i = n; tag_i = tin;
        ad_blocks_i = 8'(nad); msg_blocks_i = 8'(nmsg); data_valid_i = 1'b0;
        cyc = 1; beat = 0; nout = 0; done = 0; saw_err = 0; rdy_prev = 1'b0;
        gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // Scramble latched inputs so the core must rely on its own copies
            start_i = 1'b0; mode_i = ~dec; key_i = ~k; nonce_i = ~n;
            ad_blocks_i = 8'($urandom); msg_blocks_i = 8'($urandom);
            if (data_valid_i && rdy_prev) begin
                beat++;
                gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            end
            if (cipher_valid_o) begin
                if (nout < nmsg) check($sformatf("%s out%0d", name, nout), cipher_o, exp_out[nout]);
                else check($sformatf("%s extra output", name), 1, 0);
                nout++;
            end
            if (cmd_err_o) saw_err = 1;
            if (end_o) begin
                done = 1;
                check($sformatf("%s tag", name), tag_o, exp_tag);
                check($sformatf("%s tag_ok", name), tag_ok_o, exp_ok);
                check($sformatf("%s outputs", name), nout, nmsg);
                if (gmax == 0) check($sformatf("%s cycles", name), cyc, exp_cyc);
            end
            if (poke && cyc == 6) begin
                start_i = 1'b1; msg_blocks_i = '0;
            end
            if (gap > 0) begin
                data_valid_i = 1'b0; data_i = rnd128(); gap--;
            end else if (beat < total) begin
                data_valid_i = 1'b1;
                data_i = (beat < nad) ? ad_v[beat] : msg_v[beat - nad];
            end else begin
                data_valid_i = 1'b0; data_i = rnd128();
            end
            rdy_prev = data_ready_o;
        end
        if (!done) check($sformatf("%s end_o timeout", name), 0, 1);
        data_valid_i = 1'b0;
        @(negedge clk);
        check($sformatf("%s idle after end", name), busy_o, 0);
        check($sformatf("%s end pulse", name), end_o, 0);
        check($sformatf("%s tag held", name), tag_o, exp_tag);
        check($sformatf("%s tag_ok held", name), tag_ok_o, exp_ok);
        check($sformatf("%s no cmd_err", name), saw_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; data_valid_i = 1'b0;
        key_i = '0; nonce_i = '0; data_i = '0; tag_i = '0;
        ad_blocks_i = '0; msg_blocks_i = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy_o, 0);
        check("reset ready", data_ready_o, 0);
        check("reset tag", tag_o, 0);
        check("reset cipher", {cipher_o[126:0], cipher_valid_o}, 0);
        check("reset flags", {end_o, cmd_err_o, tag_ok_o}, 0);
        reset_i = 1'b0;

        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        n1 = k1;
        msg_v[0] = 128'h01;
        run_op("kat_empty_ad", 1'b0, k1, n1, 0, 1, '0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ad_v[i] = rnd128(); msg_v[i] = rnd128(); pt_save[i] = msg_v[i];
        end
        run_op("multi_enc", 1'b0, rnd128(), rnd128(), 3, 4, '0, 0, 0, 1'b0);

        k1 = rnd128(); n1 = rnd128();
        run_op("rt_enc", 1'b0, k1, n1, 2, 4, '0, 0, 0, 1'b0);
        t_enc = exp_tag;
        for (int i = 0; i < 4; i++) msg_v[i] = exp_out[i];
        run_op("rt_dec", 1'b1, k1, n1, 2, 4, t_enc, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("rt plaintext%0d", i), exp_out[i], pt_save[i]);
        run_op("rt_dec_badtag", 1'b1, k1, n1, 2, 4, t_enc ^ (128'd1 << 37), 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) msg_v[i] = pt_save[i];
        run_op("stress_enc", 1'b0, k1, n1, 2, 4, '0, 5, 1, 1'b0);
        check("stress tag vs rt_enc", exp_tag, t_enc);

        @(negedge clk);
        start_i = 1'b1; msg_blocks_i = '0; ad_blocks_i = 8'd2;
        @(negedge clk);
        start_i = 1'b0;
        check("cmd_err pulse", cmd_err_o, 1);
        check("cmd_err busy", busy_o, 0);
        @(negedge clk);
        check("cmd_err single", cmd_err_o, 0);
        check("cmd_err idle", busy_o, 0);
        check("cmd_err tag kept", tag_o, t_enc);

        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; key_i = k1; nonce_i = n1;
        ad_blocks_i = 8'd2; msg_blocks_i = 8'd1;
        @(negedge clk);
        start_i = 1'b0;
        w = 0;
        while (!data_ready_o && w < 100) begin
            @(negedge clk); w++;
        end
        check("mid reset ready seen", data_ready_o, 1);
        data_valid_i = 1'b1; data_i = ad_v[0];
        @(negedge clk);
        data_valid_i = 1'b0;
        check("ad_perm ready low", data_ready_o, 0);
        check("ad_perm busy", busy_o, 1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("mid reset busy", busy_o, 0);
        check("mid reset tag", tag_o, 0);
        check("mid reset ready", data_ready_o, 0);

        msg_v[0] = 128'h01;
        run_op("kat_after_reset", 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
               128'h000102030405060708090a0b0c0d0e0f, 0, 1, '0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
